// File: rtl/maze_carver_grid_if.sv
// Control/status bundle between the maze carver and its consumers (renderer, player logic).
// The optional step input exists only when MAZE_CARVER_STEP_EN is defined.
interface maze_carver_grid_if #(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16,
    parameter int XW     = ($clog2(MAZE_W) > 1) ? $clog2(MAZE_W) : 1,
    parameter int YW     = ($clog2(MAZE_H) > 1) ? $clog2(MAZE_H) : 1,
    parameter int SLW    = $clog2(((MAZE_W + 1) / 2) * ((MAZE_H + 1) / 2) + 1)
);
    logic                       start;
    logic [XW-1:0]              start_x;
    logic [YW-1:0]              start_y;
    logic                       busy;
    logic                       done;
    logic [MAZE_W*MAZE_H-1:0]   maze_data;
    logic [XW-1:0]              curr_x;
    logic [YW-1:0]              curr_y;
    logic [SLW-1:0]             stack_level;
`ifdef MAZE_CARVER_STEP_EN
    logic                       step;

    modport master (output start, start_x, start_y, step,
                    input  busy, done, maze_data, curr_x, curr_y, stack_level);
    modport slave  (input  start, start_x, start_y, step,
                    output busy, done, maze_data, curr_x, curr_y, stack_level);
`else
    modport master (output start, start_x, start_y,
                    input  busy, done, maze_data, curr_x, curr_y, stack_level);
    modport slave  (input  start, start_x, start_y,
                    output busy, done, maze_data, curr_x, curr_y, stack_level);
`endif
endinterface

// File: rtl/maze_carver_grid.sv
// Randomised depth-first (recursive-backtracker) maze generator for a MAZE_W x MAZE_H bitmap.
// Define MAZE_CARVER_STEP_EN to gate RUN actions with bus.step for animated carving.
module maze_carver_grid #(
    parameter int          MAZE_W    = 16,
    parameter int          MAZE_H    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          XW        = ($clog2(MAZE_W) > 1) ? $clog2(MAZE_W) : 1,
    parameter int          YW        = ($clog2(MAZE_H) > 1) ? $clog2(MAZE_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    maze_carver_grid_if.slave bus
);
    localparam int          CW    = (MAZE_W + 1) / 2;
    localparam int          CH    = (MAZE_H + 1) / 2;
    localparam int          N     = CW * CH;
    localparam int          NT    = MAZE_W * MAZE_H;
    localparam int          SLW   = $clog2(N + 1);
    localparam int          SAW   = (N > 1) ? $clog2(N) : 1;
    localparam int          IW    = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [XW:0] X_MAX = (XW + 1)'(MAZE_W - 1);
    localparam logic [YW:0] Y_MAX = (YW + 1)'(MAZE_H - 1);
    localparam logic [XW:0] X_ONE = (XW + 1)'(1);
    localparam logic [XW:0] X_TWO = (XW + 1)'(2);
    localparam logic [YW:0] Y_ONE = (YW + 1)'(1);
    localparam logic [YW:0] Y_TWO = (YW + 1)'(2);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr;
    logic [NT-1:0]        maze_data;
    logic [XW-1:0]        curr_x;
    logic [YW-1:0]        curr_y;
    logic [SLW-1:0]       stack_level;
    logic [SLW-1:0]       pop_level;
    logic [XW+YW-1:0]     stack_mem [2**SAW];
    logic [XW:0]          tx [4];
    logic [XW:0]          wx [4];
    logic [YW:0]          ty [4];
    logic [YW:0]          wy [4];
    logic [3:0]           dir_ok;
    logic                 found;
    logic [1:0]           dir_sel;
    logic [1:0]           cand;
    logic                 act;

    function automatic logic [IW-1:0] tile_idx(input logic [XW:0] x, input logic [YW:0] y);
        return IW'(int'(x) + MAZE_W * int'(y));
    endfunction

`ifdef MAZE_CARVER_STEP_EN
    assign act = bus.step;
`else
    assign act = 1'b1;
`endif

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Targets and walls use one extra bit so x-2 / y-2 underflow lands out of bounds
    always_comb begin
        tx[0] = {1'b0, curr_x};
        ty[0] = {1'b0, curr_y} - Y_TWO;
        wx[0] = {1'b0, curr_x};
        wy[0] = {1'b0, curr_y} - Y_ONE;
        tx[1] = {1'b0, curr_x} + X_TWO;
        ty[1] = {1'b0, curr_y};
        wx[1] = {1'b0, curr_x} + X_ONE;
        wy[1] = {1'b0, curr_y};
        tx[2] = {1'b0, curr_x};
        ty[2] = {1'b0, curr_y} + Y_TWO;
        wx[2] = {1'b0, curr_x};
        wy[2] = {1'b0, curr_y} + Y_ONE;
        tx[3] = {1'b0, curr_x} - X_TWO;
        ty[3] = {1'b0, curr_y};
        wx[3] = {1'b0, curr_x} - X_ONE;
        wy[3] = {1'b0, curr_y};
        dir_ok = '0;
        for (int d = 0; d < 4; d++) begin
            if (tx[d] <= X_MAX && ty[d] <= Y_MAX)
                dir_ok[d] = ~maze_data[tile_idx(tx[d], ty[d])];
        end
        // Scan r+3 down to r so the earliest valid direction in r order wins
        found   = 1'b0;
        dir_sel = lfsr[1:0];
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = lfsr[1:0] + 2'(k);
            if (dir_ok[cand]) begin
                found   = 1'b1;
                dir_sel = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR:        state_nxt = S_RUN;
            S_RUN:          if (act && !found && stack_level == '0) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    assign pop_level = stack_level - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            maze_data   <= '0;
            curr_x      <= '0;
            curr_y      <= '0;
            stack_level <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        curr_x <= bus.start_x & ~XW'(1);
                        curr_y <= bus.start_y & ~YW'(1);
                    end
                end
                S_CLEAR: begin
                    maze_data <= '0;
                    maze_data[tile_idx({1'b0, curr_x}, {1'b0, curr_y})] <= 1'b1;
                    stack_level <= '0;
                end
                S_RUN: begin
                    if (act && found) begin
                        maze_data[tile_idx(wx[dir_sel], wy[dir_sel])] <= 1'b1;
                        maze_data[tile_idx(tx[dir_sel], ty[dir_sel])] <= 1'b1;
                        curr_x      <= tx[dir_sel][XW-1:0];
                        curr_y      <= ty[dir_sel][YW-1:0];
                        stack_level <= stack_level + 1'b1;
                    end else if (act && stack_level != '0) begin
                        {curr_x, curr_y} <= stack_mem[pop_level[SAW-1:0]];
                        stack_level      <= pop_level;
                    end
                end
                default: ;
            endcase
        end
    end

    // Backtrack stack holds only data; occupancy lives in stack_level
    always_ff @(posedge clk) begin
        if (state == S_RUN && act && found)
            stack_mem[stack_level[SAW-1:0]] <= {curr_x, curr_y};
    end

    assign bus.busy        = (state == S_CLEAR) || (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.maze_data   = maze_data;
    assign bus.curr_x      = curr_x;
    assign bus.curr_y      = curr_y;
    assign bus.stack_level = stack_level;
endmodule
